reg4_share_arb: RTL and testbench

Round-robin write arbiter and lock controller for a shared WIDTH-bit register. Up to N_REQ requesters present data with a req/ack handshake; the block picks one winner per cycle, loads its data into the internal shared register, and returns a one-cycle ack. A requester may lock the register for a sequence of exclusive writes. The block sits between requesting units and consumers of the shared value `q`.

---
 rtl/reg4_share_arb_if.sv | 26 ++
 rtl/reg4_share_arb.sv | 112 +++++++++++
 tb/tb_reg4_share_arb.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/reg4_share_arb_if.sv
// Bus between requesters and the shared-register arbiter.
// The arbiter takes the slave modport; requesters drive the master side.
interface reg4_share_arb_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDW   = 2
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       lock;
    logic [N_REQ*WIDTH-1:0] data;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       q;
    logic [IDW-1:0]         owner;
    logic                   q_valid;
    logic                   locked;

    modport master (
        output req, lock, data,
        input  ack, q, owner, q_valid, locked
    );

    modport slave (
        input  req, lock, data,
        output ack, q, owner, q_valid, locked
    );
endinterface

// File: rtl/reg4_share_arb.sv
// Round-robin write arbiter with lock ownership for one shared register.
// All outputs come straight from flops; one write per cycle at most.
module reg4_share_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDW   = 2
) (
    input logic              clk,
    input logic              rst_n,
    reg4_share_arb_if.slave  bus
);
    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    localparam logic [IDW:0] NReqW = (IDW+1)'(N_REQ);

    state_e           state_q, state_d;
    logic [IDW-1:0]   own_q, own_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   owner_q;
    logic [IDW-1:0]   pick, win;
    logic [IDW:0]     win_inc;
    logic [N_REQ-1:0] ack_q, ack_d, elig;
    logic [WIDTH-1:0] q_q, win_data;
    logic             q_valid_q;
    logic             any_elig, wr;

    // A requester whose ack is showing is masked so a drop-on-ack gets one write.
    assign elig = bus.req & ~ack_q;

    always_comb begin
        logic [IDW:0] idx;
        idx      = '0;
        pick     = '0;
        any_elig = 1'b0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(off);
            if (idx >= NReqW) idx = idx - NReqW;
            if (!any_elig && elig[idx[IDW-1:0]]) begin
                any_elig = 1'b1;
                pick     = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        wr      = 1'b0;
        win     = pick;
        unique case (state_q)
            StIdle: begin
                if (any_elig) begin
                    wr = 1'b1;
                    if (bus.lock[pick]) begin
                        state_d = StOwned;
                        own_d   = pick;
                    end
                end
            end
            StOwned: begin
                win = own_q;
                if (elig[own_q]) begin
                    wr = 1'b1;
                    if (!bus.lock[own_q]) state_d = StIdle;
                end else if (!bus.req[own_q] && !bus.lock[own_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win == IDW'(i)) win_data = bus.data[i*WIDTH +: WIDTH];
        end
    end

    // Pointer wraps at N_REQ, not at 2**IDW, so odd requester counts stay in range.
    assign win_inc = {1'b0, win} + (IDW+1)'(1);
    assign ptr_d   = (win_inc == NReqW) ? '0 : win_inc[IDW-1:0];
    assign ack_d   = wr ? (N_REQ'(1) << win) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            own_q     <= '0;
            ptr_q     <= '0;
            owner_q   <= '0;
            ack_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ack_q   <= ack_d;
            if (wr) begin
                q_q       <= win_data;
                owner_q   <= win;
                ptr_q     <= ptr_d;
                q_valid_q <= 1'b1;
            end
        end
    end

    assign bus.ack     = ack_q;
    assign bus.q       = q_q;
    assign bus.owner   = owner_q;
    assign bus.q_valid = q_valid_q;
    assign bus.locked  = (state_q == StOwned);
endmodule

// File: tb/tb_reg4_share_arb.sv
// Directed bench for reg4_share_arb: arbitration order, locking, ack masking, async reset.
module tb_reg4_share_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;
    int   n_acks;

    reg4_share_arb_if #(.N_REQ(4), .WIDTH(4), .IDW(2)) bus ();

    reg4_share_arb #(.N_REQ(4), .WIDTH(4), .IDW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [3:0] v);
        bus.data[i*4 +: 4] = v;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".q"},       32'(bus.q),       32'h0);
        check({tag, ".ack"},     32'(bus.ack),     32'h0);
        check({tag, ".owner"},   32'(bus.owner),   32'h0);
        check({tag, ".q_valid"}, 32'(bus.q_valid), 32'h0);
        check({tag, ".locked"},  32'(bus.locked),  32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req  = '0;
        bus.lock = '0;
        bus.data = '0;
        #2;
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, dropped on ack.
        bus.req = 4'b0001;
        set_data(0, 4'hA);
        tick();
        check("single.q",       32'(bus.q),       32'hA);
        check("single.owner",   32'(bus.owner),   32'd0);
        check("single.ack",     32'(bus.ack),     32'b0001);
        check("single.q_valid", 32'(bus.q_valid), 32'd1);
        check("single.locked",  32'(bus.locked),  32'd0);
        bus.req = 4'b0000;
        tick();
        check("single.ack_off", 32'(bus.ack), 32'h0);
        check("single.q_hold",  32'(bus.q),   32'hA);

        // All four continuously requesting: rotation 0,1,2,3,0,...
        do_reset();
        for (int i = 0; i < 4; i++) set_data(i, 4'(i + 1));
        bus.req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr.owner", 32'(bus.owner), 32'(i % 4));
            check("rr.q",     32'(bus.q),     32'(i % 4 + 1));
            check("rr.ack",   32'(bus.ack),   32'(1 << (i % 4)));
        end
        bus.req = 4'b0000;
        tick();
        check("rr.ack_off", 32'(bus.ack), 32'h0);

        // Lock by requester 2 with 0 and 3 waiting; ptr is 0 here.
        bus.req  = 4'b0100;
        bus.lock = 4'b0100;
        set_data(2, 4'h5);
        tick();
        check("lk1.q",      32'(bus.q),      32'h5);
        check("lk1.ack",    32'(bus.ack),    32'b0100);
        check("lk1.locked", 32'(bus.locked), 32'd1);
        bus.req = 4'b1001;
        tick();
        check("lk2.ack",    32'(bus.ack),    32'h0);
        check("lk2.locked", 32'(bus.locked), 32'd1);
        check("lk2.q",      32'(bus.q),      32'h5);
        bus.req = 4'b1101;
        set_data(2, 4'h6);
        tick();
        check("lk3.q",      32'(bus.q),      32'h6);
        check("lk3.ack",    32'(bus.ack),    32'b0100);
        check("lk3.locked", 32'(bus.locked), 32'd1);
        bus.req = 4'b1001;
        tick();
        check("lk4.ack",    32'(bus.ack),    32'h0);
        check("lk4.q",      32'(bus.q),      32'h6);
        bus.req  = 4'b1101;
        bus.lock = 4'b0000;
        set_data(2, 4'h7);
        tick();
        check("lk5.q",      32'(bus.q),      32'h7);
        check("lk5.ack",    32'(bus.ack),    32'b0100);
        check("lk5.owner",  32'(bus.owner),  32'd2);
        check("lk5.locked", 32'(bus.locked), 32'd0);
        bus.req = 4'b1001;
        tick();
        check("lk6.owner", 32'(bus.owner), 32'd3);
        check("lk6.q",     32'(bus.q),     32'h4);
        check("lk6.ack",   32'(bus.ack),   32'b1000);
        bus.req = 4'b0000;
        tick();

        // Lock by 1, then release without a write while 0 waits; ptr is 0 here.
        set_data(0, 4'h9);
        bus.req  = 4'b0010;
        bus.lock = 4'b0010;
        tick();
        check("rel1.owner",  32'(bus.owner),  32'd1);
        check("rel1.q",      32'(bus.q),      32'h2);
        check("rel1.locked", 32'(bus.locked), 32'd1);
        bus.req = 4'b0001;
        tick();
        check("rel2.ack",    32'(bus.ack),    32'h0);
        check("rel2.locked", 32'(bus.locked), 32'd1);
        bus.lock = 4'b0000;
        tick();
        check("rel3.locked", 32'(bus.locked), 32'd0);
        check("rel3.ack",    32'(bus.ack),    32'h0);
        check("rel3.q",      32'(bus.q),      32'h2);
        check("rel3.owner",  32'(bus.owner),  32'd1);
        tick();
        check("rel4.owner", 32'(bus.owner), 32'd0);
        check("rel4.q",     32'(bus.q),     32'h9);
        check("rel4.ack",   32'(bus.ack),   32'b0001);
        bus.req = 4'b0000;
        tick();

        // Held request alone: acks every other cycle.
        set_data(3, 4'hF);
        bus.req = 4'b1000;
        n_acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("hold.ack", 32'(bus.ack), (i % 2 == 0) ? 32'b1000 : 32'h0);
            check("hold.q",   32'(bus.q),   32'hF);
            if (bus.ack[3]) n_acks++;
        end
        check("hold.count", 32'(n_acks), 32'd3);
        bus.req = 4'b0000;
        tick();

        // Async reset mid-lock with an ack showing.
        bus.req  = 4'b0100;
        bus.lock = 4'b0100;
        tick();
        check("mrst.locked_pre", 32'(bus.locked), 32'd1);
        check("mrst.ack_pre",    32'(bus.ack),    32'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mrst");
        bus.req  = 4'b1010;
        bus.lock = 4'b0000;
        #2;
        rst_n = 1'b1;
        tick();
        check("mrst.owner",  32'(bus.owner),  32'd1);
        check("mrst.ack",    32'(bus.ack),    32'b0010);
        check("mrst.q",      32'(bus.q),      32'h2);
        check("mrst.locked", 32'(bus.locked), 32'd0);
        bus.req = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
